// File: rtl/fpu_pipe_param.sv
// Parametrised multi-cycle FPU with a fixed EXEC -> NORM -> PACK sequence.
// All arithmetic truncates; exp==0 words are zero; no inf/NaN encodings.
module fpu_pipe_param #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 7,
  parameter int BIAS   = 127,
  parameter int W      = 1 + EXP_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);
  localparam int M   = MANT_W + 1;
  localparam int AW  = MANT_W + 3;
  localparam int PW  = 2 * M;
  localparam int TW  = W + M;
  localparam int MW0 = (PW > W) ? PW : W;
  localparam int MW  = (MW0 > AW + 1) ? MW0 : AW + 1;
  localparam int EW  = EXP_W + 4;
  localparam int LW  = $clog2(MW + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_ITOF = 3'd3;
  localparam logic [2:0] OP_FTOI = 3'd4;

  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, EXEC, NORM, PACK} state_t;
  state_t state, state_nx;

  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;

  logic                 x_pass, x_pass_d;
  logic [W-1:0]         x_val, x_val_d;
  logic                 x_sign, x_sign_d;
  logic signed [EW-1:0] x_exp, x_exp_d;
  logic [MW-1:0]        x_mag, x_mag_d;

  logic                 n_pass, n_sign;
  logic [W-1:0]         n_val;
  logic signed [EW-1:0] n_exp, n_exp_d;
  logic [MANT_W-1:0]    n_mant;

  logic              sa, sb, za, zb;
  logic [EXP_W-1:0]  ea, eb, big_e, diff, e_u;
  logic [MANT_W-1:0] fa, fb, big_f, small_f;
  logic              a_big, is_add, is_mul, is_itof, is_ftoi;
  logic [AW-1:0]     big_m, small_m;
  logic [AW:0]       sum;
  logic [PW-1:0]     prod;
  logic [W-1:0]      babs, imag, ival;
  logic [TW-1:0]     ftoi_t;
  logic [LW-1:0]     lz;
  logic [MW-1:0]     nrm;
  logic [W-1:0]      res_d;
  logic              unused_bits;

  function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LW'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc = LW'(MW - 1 - i);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = EXEC;
      EXEC:    state_nx = NORM;
      NORM:    state_nx = PACK;
      PACK:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  assign sa = a_q[W-1];
  assign ea = a_q[W-2:MANT_W];
  assign fa = a_q[MANT_W-1:0];
  assign za = (ea == '0);
  assign sb = b_q[W-1] ^ (op_q == OP_SUB);
  assign eb = b_q[W-2:MANT_W];
  assign fb = b_q[MANT_W-1:0];
  assign zb = (eb == '0);

  assign is_add  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_mul  = (op_q == OP_MUL);
  assign is_itof = (op_q == OP_ITOF);
  assign is_ftoi = (op_q == OP_FTOI);

  always_comb begin
    a_big   = a_q[W-2:0] >= b_q[W-2:0];
    big_e   = a_big ? ea : eb;
    big_f   = a_big ? fa : fb;
    small_f = a_big ? fb : fa;
    diff    = big_e - (a_big ? eb : ea);
    big_m   = {1'b1, big_f, 2'b00};
    small_m = {1'b1, small_f, 2'b00} >> diff;
    if (sa == sb) sum = {1'b0, big_m} + {1'b0, small_m};
    else          sum = {1'b0, big_m} - {1'b0, small_m};
    prod    = PW'({1'b1, fa}) * PW'({1'b1, fb});
    babs    = b_q[W-1] ? -b_q : b_q;
    e_u     = eb - EXP_W'(BIAS);
    ftoi_t  = TW'({1'b1, fb}) << e_u;
    imag    = ftoi_t[W+MANT_W-1:MANT_W];
    ival    = sb ? -imag : imag;
  end

  // Non-pass results leave EXEC as mag/2^(MW-1) * 2^(exp-BIAS).
  always_comb begin
    x_pass_d = 1'b1;
    x_val_d  = '0;
    x_sign_d = 1'b0;
    x_exp_d  = '0;
    x_mag_d  = '0;
    unique case (1'b1)
      is_add: begin
        if (za) begin
          if (!zb) x_val_d = {sb, b_q[W-2:0]};
        end else if (zb) begin
          x_val_d = {sa, a_q[W-2:0]};
        end else if (sum != '0) begin
          x_pass_d = 1'b0;
          x_sign_d = a_big ? sa : sb;
          x_exp_d  = EW'(big_e) + EW'(1);
          x_mag_d  = MW'(sum) << (MW - AW - 1);
        end
      end
      is_mul: begin
        if (!za && !zb) begin
          x_pass_d = 1'b0;
          x_sign_d = sa ^ sb;
          x_exp_d  = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(1);
          x_mag_d  = MW'(prod) << (MW - PW);
        end
      end
      is_itof: begin
        if (b_q != '0) begin
          x_pass_d = 1'b0;
          x_sign_d = b_q[W-1];
          x_exp_d  = EW'(BIAS + W - 1);
          x_mag_d  = MW'(babs) << (MW - W);
        end
      end
      is_ftoi: begin
        if (zb || int'(eb) < BIAS)
          x_val_d = '0;
        else if (int'(eb) - BIAS >= W - 1)
          x_val_d = sb ? {1'b1, {(W-1){1'b0}}}
                       : {1'b0, {(W-1){1'b1}}};
        else
          x_val_d = ival;
      end
      default: ;
    endcase
  end

  always_comb begin
    lz      = lzc(x_mag);
    nrm     = x_mag << lz;
    n_exp_d = x_exp - EW'(lz);
  end

  always_comb begin
    res_d = {n_sign, n_exp[EXP_W-1:0], n_mant};
    if (n_pass)
      res_d = n_val;
    else if (n_exp > EXP_MAX)
      res_d = {n_sign, {(W-1){1'b1}}};
    else if (n_exp < EXP_ONE)
      res_d = '0;
  end

  assign unused_bits = ^{ftoi_t[MANT_W-1:0], ftoi_t[TW-1],
                         nrm[MW-1], nrm[MW-2-MANT_W:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      x_pass <= 1'b0;
      x_val  <= '0;
      x_sign <= 1'b0;
      x_exp  <= '0;
      x_mag  <= '0;
      n_pass <= 1'b0;
      n_val  <= '0;
      n_sign <= 1'b0;
      n_exp  <= '0;
      n_mant <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == PACK);
      if (state == IDLE && start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (state == EXEC) begin
        x_pass <= x_pass_d;
        x_val  <= x_val_d;
        x_sign <= x_sign_d;
        x_exp  <= x_exp_d;
        x_mag  <= x_mag_d;
      end
      if (state == NORM) begin
        n_pass <= x_pass;
        n_val  <= x_val;
        n_sign <= x_sign;
        n_exp  <= n_exp_d;
        n_mant <= nrm[MW-2 -: MANT_W];
      end
      if (state == PACK) result <= res_d;
    end
  end
endmodule

// File: tb/tb_fpu_pipe_param.sv
// Directed bench for fpu_pipe_param: scoreboard of expected results,
// latency, handshake and asynchronous reset checks.
module tb_fpu_pipe_param;
  localparam int W = 16;
  localparam logic [2:0] ADDF = 3'd0;
  localparam logic [2:0] SUBF = 3'd1;
  localparam logic [2:0] MULF = 3'd2;
  localparam logic [2:0] ITOF = 3'd3;
  localparam logic [2:0] FTOI = 3'd4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [W-1:0] want;

  int vecs = 0;
  int errs = 0;
  logic [W-1:0] sb_q[$];

  fpu_pipe_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp_v);
    vecs++;
    assert (got === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] r);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sb_q.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int n0);
    int n;
    logic [W-1:0] r;
    n = n0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      chk({tag, "-busy"}, W'(busy), W'(1));
    end
    chk({tag, "-lat"}, W'(n), W'(3));
    r = 'x;
    if (sb_q.size() > 0) r = sb_q.pop_front();
    chk({tag, "-res"}, result, r);
    chk({tag, "-idle"}, W'(busy), W'(0));
    @(posedge clk);
    #1;
    chk({tag, "-pulse"}, W'(done), W'(0));
    chk({tag, "-hold"}, result, r);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] r);
    issue(o, x, y, r);
    wait_done(tag, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst-busy", W'(busy), W'(0));
    chk("rst-done", W'(done), W'(0));
    chk("rst-res", result, 16'h0000);
    rst_n = 1'b1;

    do_op("add-1p2", ADDF, 16'h3F80, 16'h4000, 16'h4040);
    do_op("sub-1m1", SUBF, 16'h3F80, 16'h3F80, 16'h0000);
    do_op("sub-1m2", SUBF, 16'h3F80, 16'h4000, 16'hBF80);
    do_op("add-zero", ADDF, 16'h0000, 16'hC000, 16'hC000);
    do_op("sub-zero", SUBF, 16'h4000, 16'h0000, 16'h4000);
    do_op("add-far", ADDF, 16'h4500, 16'h3F80, 16'h4500);
    do_op("add-sat", ADDF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    do_op("mul-2p25", MULF, 16'h3FC0, 16'h3FC0, 16'h4010);
    do_op("mul-neg", MULF, 16'hBFC0, 16'h3FC0, 16'hC010);
    do_op("mul-sat", MULF, 16'h7F00, 16'h7F00, 16'h7FFF);
    do_op("mul-flush", MULF, 16'h0080, 16'h0080, 16'h0000);
    do_op("itof-pos", ITOF, 16'h1234, 16'd1784, 16'h44DF);
    do_op("itof-neg", ITOF, 16'h1234, 16'hF908, 16'hC4DF);
    do_op("itof-min", ITOF, 16'h1234, 16'h8000, 16'hC700);
    do_op("itof-zero", ITOF, 16'h1234, 16'h0000, 16'h0000);
    do_op("ftoi-neg", FTOI, 16'h1234, 16'hC4DF, 16'hF908);
    do_op("ftoi-half", FTOI, 16'h1234, 16'h3F00, 16'h0000);
    do_op("ftoi-psat", FTOI, 16'h1234, 16'h4780, 16'h7FFF);
    do_op("ftoi-nsat", FTOI, 16'h1234, 16'hC780, 16'h8000);
    do_op("bad-op", 3'd5, 16'h3F80, 16'h4000, 16'h0000);

    @(negedge clk);
    start = 1'b1;
    op = ADDF;
    a = 16'h3F80;
    b = 16'h4000;
    repeat (3) sb_q.push_back(16'h4040);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hs%0d-done", k), W'(done), W'(k % 4 == 3));
      chk($sformatf("hs%0d-busy", k), W'(busy), W'(k % 4 != 3));
      if (done) begin
        want = 'x;
        if (sb_q.size() > 0) want = sb_q.pop_front();
        chk($sformatf("hs%0d-res", k), result, want);
      end
      if (k == 11) start = 1'b0;
    end

    issue(ADDF, 16'h3F80, 16'h4000, 16'h4040);
    @(negedge clk);
    start = 1'b1;
    op = MULF;
    a = 16'h7F00;
    b = 16'h7F00;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ign%0d-busy", k), W'(busy), W'(0));
      chk($sformatf("ign%0d-done", k), W'(done), W'(0));
    end

    @(negedge clk);
    start = 1'b1;
    op = MULF;
    a = 16'h3FC0;
    b = 16'h3FC0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-busy", W'(busy), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst-busy", W'(busy), W'(0));
    chk("arst-done", W'(done), W'(0));
    chk("arst-res", result, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post-rst-busy", W'(busy), W'(0));
    do_op("itof-after", ITOF, 16'h0000, 16'd1784, 16'h44DF);

    chk("sb-empty", W'(sb_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
